// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite mover/renderer.
package sprite_pkg;

  // Controller states: idle, erasing the old footprint, drawing the new one.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ERASE = 2'd1,
    S_DRAW  = 2'd2
  } state_e;

  // Bit positions inside the 4-bit direction request.
  localparam int DIR_RIGHT = 0;
  localparam int DIR_UP    = 1;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 3;

  // Width of a pixel-counter axis; a 1-pixel sprite still needs one bit.
  function automatic int cnt_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/sprite_engine_edge_step.sv
// One axis of sprite movement: applies -STEP/0/+STEP to the current
// top-left coordinate and then clamps or wraps it so the whole sprite
// stays on screen. hit_o flags that the edge rule changed the result.
module edge_step #(
  parameter int W         = 8,
  parameter int MAX       = 159,
  parameter int SIZE      = 4,
  parameter int STEP      = 1,
  parameter int EDGE_MODE = 0
) (
  input  logic [W-1:0] pos_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] nxt_o,
  output logic         hit_o
);

  // Last legal top-left coordinate and the wrap period (number of legal positions).
  localparam int                LIM    = MAX - SIZE + 1;
  localparam logic signed [W:0] LIM_S  = (W+1)'(LIM);
  localparam logic signed [W:0] SPAN_S = (W+1)'(LIM + 1);
  localparam logic signed [W:0] STEP_S = (W+1)'(STEP);

  logic signed [W:0] sum;
  logic signed [W:0] adj;

  // Signed one-bit-wider arithmetic so a step below zero is visible as negative.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a value unassigned and infers a latch.
    sum   = $signed({1'b0, pos_i});
    adj   = '0;
    hit_o = 1'b0;
    // Opposite requests on the same axis cancel.
    if (inc_i && !dec_i) begin
      sum = sum + STEP_S;
    end else if (dec_i && !inc_i) begin
      sum = sum - STEP_S;
    end
    adj = sum;
    if (sum > LIM_S) begin
      hit_o = 1'b1;
      adj   = (EDGE_MODE != 0) ? (sum - SPAN_S) : LIM_S;
    end else if (sum[W]) begin
      hit_o = 1'b1;
      adj   = (EDGE_MODE != 0) ? (sum + SPAN_S) : '0;
    end
    nxt_o = adj[W-1:0];
  end

endmodule

// File: rtl/sprite_engine.sv
// Sprite mover/renderer: on a tick or load it erases the sprite's old
// footprint in bg_colour, moves it, and redraws it in fg_colour, emitting
// one pixel per accepted plot/plot_ready handshake.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int SIZE      = 4,
  parameter int X_MAX     = 159,
  parameter int Y_MAX     = 119,
  parameter int STEP      = 1,
  parameter int EDGE_MODE = 0,
  parameter int INIT_X    = 0,
  parameter int INIT_Y    = 0,
  parameter int C_W       = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic [3:0]     dir,
  input  logic           load,
  input  logic [X_W-1:0] load_x,
  input  logic [Y_W-1:0] load_y,
  input  logic [C_W-1:0] fg_colour,
  input  logic [C_W-1:0] bg_colour,
  output logic           plot,
  input  logic           plot_ready,
  output logic [X_W-1:0] plot_x,
  output logic [Y_W-1:0] plot_y,
  output logic [C_W-1:0] plot_colour,
  output logic           busy,
  output logic [X_W-1:0] pos_x,
  output logic [Y_W-1:0] pos_y,
  output logic           edge_hit
);

  localparam int             CNT_W  = cnt_width(SIZE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SIZE - 1);
  localparam logic [X_W-1:0] X_LIM  = X_W'(X_MAX - SIZE + 1);
  localparam logic [Y_W-1:0] Y_LIM  = Y_W'(Y_MAX - SIZE + 1);
  localparam logic [X_W-1:0] X_INIT = X_W'(INIT_X);
  localparam logic [Y_W-1:0] Y_INIT = Y_W'(INIT_Y);

  state_e           state_q, state_d;
  logic [X_W-1:0]   pos_x_q, pos_x_d;
  logic [Y_W-1:0]   pos_y_q, pos_y_d;
  logic [X_W-1:0]   nxt_x_q, nxt_x_d;
  logic [Y_W-1:0]   nxt_y_q, nxt_y_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             init_pending_q, init_pending_d;
  logic             edge_hit_q, edge_hit_d;

  logic [X_W-1:0]   step_x;
  logic [Y_W-1:0]   step_y;
  logic             hit_x, hit_y;
  logic [X_W-1:0]   load_x_cl;
  logic [Y_W-1:0]   load_y_cl;
  logic             accept;
  logic             last_pix;

  // Candidate positions for a tick, computed from the live dir request.
  edge_step #(
    .W(X_W), .MAX(X_MAX), .SIZE(SIZE), .STEP(STEP), .EDGE_MODE(EDGE_MODE)
  ) u_step_x (
    .pos_i (pos_x_q),
    .inc_i (dir[DIR_RIGHT]),
    .dec_i (dir[DIR_LEFT]),
    .nxt_o (step_x),
    .hit_o (hit_x)
  );

  edge_step #(
    .W(Y_W), .MAX(Y_MAX), .SIZE(SIZE), .STEP(STEP), .EDGE_MODE(EDGE_MODE)
  ) u_step_y (
    .pos_i (pos_y_q),
    .inc_i (dir[DIR_DOWN]),
    .dec_i (dir[DIR_UP]),
    .nxt_o (step_y),
    .hit_o (hit_y)
  );

  // A relocation request is always pulled fully on screen.
  assign load_x_cl = (load_x > X_LIM) ? X_LIM : load_x;
  assign load_y_cl = (load_y > Y_LIM) ? Y_LIM : load_y;

  // Pixel handshake and sweep bookkeeping.
  assign busy     = (state_q != S_IDLE);
  assign plot     = busy;
  assign accept   = plot && plot_ready;
  assign last_pix = (col_q == LAST) && (row_q == LAST);

  // During ERASE pos still holds the old position; it moves only at the
  // ERASE->DRAW boundary, so both phases share the same base.
  assign plot_x   = pos_x_q + X_W'(col_q);
  assign plot_y   = pos_y_q + Y_W'(row_q);
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign edge_hit = edge_hit_q;

  // Pixel colour follows the phase; colour inputs are used live.
  always_comb begin
    plot_colour = '0;
    case (state_q)
      S_ERASE: plot_colour = bg_colour;
      S_DRAW:  plot_colour = fg_colour;
      default: plot_colour = '0;
    endcase
  end

  // Controller: event priority in IDLE, raster sweep in ERASE/DRAW.
  always_comb begin
    state_d        = state_q;
    pos_x_d        = pos_x_q;
    pos_y_d        = pos_y_q;
    nxt_x_d        = nxt_x_q;
    nxt_y_d        = nxt_y_q;
    col_d          = col_q;
    row_d          = row_q;
    init_pending_d = init_pending_q;
    edge_hit_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_pending_q) begin
          // First paint after reset: nothing to erase yet.
          init_pending_d = 1'b0;
          state_d        = S_DRAW;
        end else if (load) begin
          nxt_x_d = load_x_cl;
          nxt_y_d = load_y_cl;
          state_d = S_ERASE;
        end else if (tick) begin
          // A clamped move may land where it started: report the edge but
          // skip the redraw.
          nxt_x_d    = step_x;
          nxt_y_d    = step_y;
          edge_hit_d = hit_x || hit_y;
          if ((step_x != pos_x_q) || (step_y != pos_y_q)) begin
            state_d = S_ERASE;
          end
        end
      end

      S_ERASE, S_DRAW: begin
        if (accept) begin
          if (last_pix) begin
            col_d = '0;
            row_d = '0;
            if (state_q == S_ERASE) begin
              pos_x_d = nxt_x_q;
              pos_y_d = nxt_y_q;
              state_d = S_DRAW;
            end else begin
              state_d = S_IDLE;
            end
          end else if (col_q == LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // its pre-edge value, independent of statement order.
    if (reset) begin
      state_q        <= S_IDLE;
      pos_x_q        <= X_INIT;
      pos_y_q        <= Y_INIT;
      nxt_x_q        <= X_INIT;
      nxt_y_q        <= Y_INIT;
      col_q          <= '0;
      row_q          <= '0;
      init_pending_q <= 1'b1;
      edge_hit_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      pos_x_q        <= pos_x_d;
      pos_y_q        <= pos_y_d;
      nxt_x_q        <= nxt_x_d;
      nxt_y_q        <= nxt_y_d;
      col_q          <= col_d;
      row_q          <= row_d;
      init_pending_q <= init_pending_d;
      edge_hit_q     <= edge_hit_d;
    end
  end

endmodule

// File: tb/tb_sprite_engine.sv
// Scoreboard bench for sprite_engine: stimulus pushes the expected pixel
// stream into a queue, a negedge monitor compares every presented pixel.
// A clamp-mode instance covers most behaviour; a wrap-mode instance covers
// the wrap edge.
module tb_sprite_engine;

  localparam int SZ = 4;
  localparam int FG = 5;
  localparam int BG = 2;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t exp0[$];
  pix_t exp1[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   acc0  = 0;
  int   acc1  = 0;

  logic       clk = 1'b0;
  logic [2:0] fg_colour = 3'(FG);
  logic [2:0] bg_colour = 3'(BG);

  // Clamp-mode instance signals
  logic       reset = 1'b1;
  logic       tick = 1'b0, load = 1'b0, plot_ready = 1'b1;
  logic [3:0] dir = '0;
  logic [7:0] load_x = '0;
  logic [6:0] load_y = '0;
  logic       plot, busy, edge_hit;
  logic [7:0] plot_x, pos_x;
  logic [6:0] plot_y, pos_y;
  logic [2:0] plot_colour;

  // Wrap-mode instance signals
  logic       w_reset = 1'b1;
  logic       w_tick = 1'b0, w_load = 1'b0, w_ready = 1'b1;
  logic [3:0] w_dir = '0;
  logic [7:0] w_load_x = '0;
  logic [6:0] w_load_y = '0;
  logic       w_plot, w_busy, w_edge_hit;
  logic [7:0] w_plot_x, w_pos_x;
  logic [6:0] w_plot_y, w_pos_y;
  logic [2:0] w_plot_colour;

  always #5 clk = ~clk;

  sprite_engine #(.EDGE_MODE(0)) u_dut (
    .clk(clk), .reset(reset), .tick(tick), .dir(dir), .load(load),
    .load_x(load_x), .load_y(load_y), .fg_colour(fg_colour), .bg_colour(bg_colour),
    .plot(plot), .plot_ready(plot_ready), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .busy(busy), .pos_x(pos_x), .pos_y(pos_y),
    .edge_hit(edge_hit)
  );

  sprite_engine #(.EDGE_MODE(1)) u_wrap (
    .clk(clk), .reset(w_reset), .tick(w_tick), .dir(w_dir), .load(w_load),
    .load_x(w_load_x), .load_y(w_load_y), .fg_colour(fg_colour), .bg_colour(bg_colour),
    .plot(w_plot), .plot_ready(w_ready), .plot_x(w_plot_x), .plot_y(w_plot_y),
    .plot_colour(w_plot_colour), .busy(w_busy), .pos_x(w_pos_x), .pos_y(w_pos_y),
    .edge_hit(w_edge_hit)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected raster sweep of one SZ x SZ footprint.
  task automatic push_sweep(input int which, input int bx, input int by, input int c);
    for (int r = 0; r < SZ; r++) begin
      for (int k = 0; k < SZ; k++) begin
        pix_t p;
        p = '{bx + k, by + r, c};
        if (which == 0) exp0.push_back(p);
        else            exp1.push_back(p);
      end
    end
  endtask

  // One-cycle tick or load strobe; returns #1 after the sampling edge.
  task automatic pulse(input int which, input bit is_load, input logic [3:0] d,
                       input int lx, input int ly);
    @(posedge clk); #1;
    if (which == 0) begin
      tick = !is_load; load = is_load; dir = d; load_x = 8'(lx); load_y = 7'(ly);
    end else begin
      w_tick = !is_load; w_load = is_load; w_dir = d; w_load_x = 8'(lx); w_load_y = 7'(ly);
    end
    @(posedge clk); #1;
    tick = 1'b0; load = 1'b0; dir = '0;
    w_tick = 1'b0; w_load = 1'b0; w_dir = '0;
  endtask

  // Bounded wait for the expected stream to drain and the engine to go idle.
  task automatic wait_idle(input int which, input string name);
    int n;
    n = 0;
    if (which == 0) begin
      while ((exp0.size() != 0 || busy) && n < 1000) begin @(posedge clk); #1; n++; end
      check({name, "_done"}, 32'(exp0.size() == 0 && !busy), 1);
    end else begin
      while ((exp1.size() != 0 || w_busy) && n < 1000) begin @(posedge clk); #1; n++; end
      check({name, "_done"}, 32'(exp1.size() == 0 && !w_busy), 1);
    end
  endtask

  // Monitor for the clamp-mode instance; also checks held values while stalled.
  always @(negedge clk) begin
    if (!reset && plot) begin
      if (exp0.size() == 0) begin
        check("m0_unexpected_pixel", 32'(plot), 0);
      end else begin
        check("m0_x", 32'(plot_x), exp0[0].x);
        check("m0_y", 32'(plot_y), exp0[0].y);
        check("m0_colour", 32'(plot_colour), exp0[0].c);
        if (plot_ready) begin
          void'(exp0.pop_front());
          acc0++;
        end
      end
    end
  end

  // Monitor for the wrap-mode instance.
  always @(negedge clk) begin
    if (!w_reset && w_plot) begin
      if (exp1.size() == 0) begin
        check("m1_unexpected_pixel", 32'(w_plot), 0);
      end else begin
        check("m1_x", 32'(w_plot_x), exp1[0].x);
        check("m1_y", 32'(w_plot_y), exp1[0].y);
        check("m1_colour", 32'(w_plot_colour), exp1[0].c);
        if (w_ready) begin
          void'(exp1.pop_front());
          acc1++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_plot", 32'(plot), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_edge_hit", 32'(edge_hit), 0);
    check("rst_colour", 32'(plot_colour), 0);
    check("rst_plot_x", 32'(plot_x), 0);
    check("rst_plot_y", 32'(plot_y), 0);
    check("rst_pos_x", 32'(pos_x), 0);

    // Initial paint at (0,0) on both instances
    push_sweep(0, 0, 0, FG);
    push_sweep(1, 0, 0, FG);
    a0 = acc0;
    reset = 1'b0;
    w_reset = 1'b0;
    @(posedge clk); #1;
    check("init_busy", 32'(busy), 1);
    wait_idle(0, "init");
    check("init_count", 32'(acc0 - a0), 16);
    wait_idle(1, "w_init");

    // Relocate to (10,10)
    push_sweep(0, 0, 0, BG);
    push_sweep(0, 10, 10, FG);
    pulse(0, 1'b1, 4'b0000, 10, 10);
    wait_idle(0, "load10");
    check("load10_pos_x", 32'(pos_x), 10);
    check("load10_pos_y", 32'(pos_y), 10);

    // Ready-high move right: exactly 32 busy cycles
    push_sweep(0, 10, 10, BG);
    push_sweep(0, 11, 10, FG);
    a0 = acc0;
    pulse(0, 1'b0, 4'b0001, 0, 0);
    check("mvA_busy_first", 32'(busy), 1);
    check("mvA_edge_hit", 32'(edge_hit), 0);
    check("mvA_pos_x_held", 32'(pos_x), 10);
    repeat (31) @(posedge clk);
    #1;
    check("mvA_busy_last", 32'(busy), 1);
    @(posedge clk); #1;
    check("mvA_busy_end", 32'(busy), 0);
    check("mvA_count", 32'(acc0 - a0), 32);
    check("mvA_pos_x", 32'(pos_x), 11);
    check("mvA_pos_y", 32'(pos_y), 10);

    // Move with 5-cycle backpressure mid-erase; tick and load while busy are dropped
    push_sweep(0, 11, 10, BG);
    push_sweep(0, 12, 10, FG);
    a0 = acc0;
    pulse(0, 1'b0, 4'b0001, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    plot_ready = 1'b0;
    tick = 1'b1; load = 1'b1; dir = 4'b1000; load_x = 8'd80; load_y = 7'd40;
    @(posedge clk); #1;
    tick = 1'b0; load = 1'b0; dir = '0;
    repeat (4) @(posedge clk);
    #1;
    plot_ready = 1'b1;
    wait_idle(0, "mvB");
    check("mvB_count", 32'(acc0 - a0), 32);
    check("mvB_pos_x", 32'(pos_x), 12);
    check("mvB_pos_y", 32'(pos_y), 10);

    // Relocation beyond the screen is clamped to (156,116)
    push_sweep(0, 12, 10, BG);
    push_sweep(0, 156, 116, FG);
    pulse(0, 1'b1, 4'b0000, 200, 127);
    wait_idle(0, "ldclamp");
    check("ldclamp_pos_x", 32'(pos_x), 156);
    check("ldclamp_pos_y", 32'(pos_y), 116);

    push_sweep(0, 156, 116, BG);
    push_sweep(0, 156, 0, FG);
    pulse(0, 1'b1, 4'b0000, 156, 0);
    wait_idle(0, "ld156");

    // Clamped move at the top-right corner: edge pulse, no redraw
    pulse(0, 1'b0, 4'b0011, 0, 0);
    check("clamp_edge_hit", 32'(edge_hit), 1);
    check("clamp_busy", 32'(busy), 0);
    @(posedge clk); #1;
    check("clamp_edge_hit_end", 32'(edge_hit), 0);
    check("clamp_busy_later", 32'(busy), 0);
    check("clamp_pos_x", 32'(pos_x), 156);
    check("clamp_pos_y", 32'(pos_y), 0);

    // Cancelling directions: no motion
    pulse(0, 1'b0, 4'b1001, 0, 0);
    check("cancel_x_busy", 32'(busy), 0);
    check("cancel_x_edge", 32'(edge_hit), 0);
    pulse(0, 1'b0, 4'b0110, 0, 0);
    check("cancel_y_busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("cancel_pos_x", 32'(pos_x), 156);

    // Reset in the middle of DRAW: sweep abandoned, fresh initial paint
    push_sweep(0, 156, 0, BG);
    push_sweep(0, 50, 50, FG);
    pulse(0, 1'b1, 4'b0000, 50, 50);
    repeat (20) @(posedge clk);
    #1;
    check("midrst_busy_before", 32'(busy), 1);
    reset = 1'b1;
    exp0.delete();
    @(posedge clk); #1;
    check("midrst_plot", 32'(plot), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pos_x", 32'(pos_x), 0);
    check("midrst_pos_y", 32'(pos_y), 0);
    push_sweep(0, 0, 0, FG);
    a0 = acc0;
    reset = 1'b0;
    wait_idle(0, "reinit");
    check("reinit_count", 32'(acc0 - a0), 16);

    // Wrap instance: left from x=0 lands at x=156, right from 156 lands at 0
    push_sweep(1, 0, 0, BG);
    push_sweep(1, 0, 5, FG);
    pulse(1, 1'b1, 4'b0000, 0, 5);
    wait_idle(1, "w_load");
    check("w_load_pos_y", 32'(w_pos_y), 5);

    push_sweep(1, 0, 5, BG);
    push_sweep(1, 156, 5, FG);
    a1 = acc1;
    pulse(1, 1'b0, 4'b1000, 0, 0);
    check("wrapL_edge_hit", 32'(w_edge_hit), 1);
    check("wrapL_busy", 32'(w_busy), 1);
    wait_idle(1, "wrapL");
    check("wrapL_count", 32'(acc1 - a1), 32);
    check("wrapL_pos_x", 32'(w_pos_x), 156);
    check("wrapL_pos_y", 32'(w_pos_y), 5);

    push_sweep(1, 156, 5, BG);
    push_sweep(1, 0, 5, FG);
    pulse(1, 1'b0, 4'b0001, 0, 0);
    check("wrapR_edge_hit", 32'(w_edge_hit), 1);
    wait_idle(1, "wrapR");
    check("wrapR_pos_x", 32'(w_pos_x), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
